// File: rtl/alu_pkg.sv
// Shared ALU op codes and MIPS R-type funct values for the execute stage.
package alu_pkg;

  localparam int OP_W    = 4;
  localparam int FUNCT_W = 6;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [OP_W-1:0] ALU_SLL = 4'b1101;
  localparam logic [OP_W-1:0] ALU_SRL = 4'b1110;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS R-type funct -> ALU op decoder with shift and illegal flags.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [OP_W-1:0]    op,
  output logic               is_shift,
  output logic               illegal
);

  always_comb begin
    op       = ALU_AND;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (funct)
      FUNCT_AND:              op = ALU_AND;
      FUNCT_OR:               op = ALU_OR;
      FUNCT_ADD, FUNCT_ADDU:  op = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU:  op = ALU_SUB;
      FUNCT_SLT:              op = ALU_SLT;
      FUNCT_NOR:              op = ALU_NOR;
      FUNCT_SLL: begin
        op       = ALU_SLL;
        is_shift = 1'b1;
      end
      FUNCT_SRL: begin
        op       = ALU_SRL;
        is_shift = 1'b1;
      end
      default:                illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage EX/WB issue controller for the external 32-bit ALU with valid/ready backpressure.
// Optional retire/illegal counters are enabled with `define ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [WIDTH-1:0]   in_rs,
  input  logic [WIDTH-1:0]   in_rt,
  input  logic [4:0]         in_shamt,
  input  logic [RD_W-1:0]    in_rd,
  output logic [OP_W-1:0]    alu_op,
  output logic [WIDTH-1:0]   alu_first,
  output logic [WIDTH-1:0]   alu_second,
  output logic [4:0]         alu_shamt,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic               wb_we,
  output logic [RD_W-1:0]    wb_rd,
  output logic [WIDTH-1:0]   wb_data,
  output logic               wb_zero,
`ifdef ALU_ISSUE_STATS_EN
  output logic [31:0]        stat_retired,
  output logic [15:0]        stat_illegal,
`endif
  output logic               wb_illegal
);

  logic [OP_W-1:0] dec_op;
  logic            dec_is_shift;
  logic            dec_illegal;

  alu_funct_decode u_decode (
    .funct    (in_funct),
    .op       (dec_op),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  // Stage 1: decoded request; drives the ALU directly.
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_first_q, s1_first_d;
  logic [WIDTH-1:0] s1_second_q, s1_second_d;
  logic [4:0]       s1_shamt_q, s1_shamt_d;
  logic [RD_W-1:0]  s1_rd_q, s1_rd_d;
  logic             s1_illegal_q, s1_illegal_d;

  // Stage 2: captured write-back beat.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_zero_q, s2_zero_d;
  logic [RD_W-1:0]  s2_rd_q, s2_rd_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic             s2_we_q, s2_we_d;

  logic s1_adv;
  logic accept;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || wb_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_first_d   = s1_first_q;
    s1_second_d  = s1_second_q;
    s1_shamt_d   = s1_shamt_q;
    s1_rd_d      = s1_rd_q;
    s1_illegal_d = s1_illegal_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = dec_illegal ? ALU_AND : dec_op;
      s1_rd_d      = in_rd;
      s1_illegal_d = dec_illegal;
      if (dec_illegal) begin
        s1_first_d  = '0;
        s1_second_d = '0;
        s1_shamt_d  = '0;
      end else if (dec_is_shift) begin
        s1_first_d  = in_rt;
        s1_second_d = '0;
        s1_shamt_d  = in_shamt;
      end else begin
        s1_first_d  = in_rs;
        s1_second_d = in_rt;
        s1_shamt_d  = '0;
      end
    end else if (s1_adv) begin
      // Operands are left in place so the ALU inputs do not toggle needlessly.
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_zero_d    = s2_zero_q;
    s2_rd_d      = s2_rd_q;
    s2_illegal_d = s2_illegal_q;
    s2_we_d      = s2_we_q;
    if (s1_adv) begin
      s2_valid_d   = 1'b1;
      s2_data_d    = s1_illegal_q ? '0 : alu_result;
      s2_zero_d    = s1_illegal_q ? 1'b0 : alu_zero;
      s2_rd_d      = s1_rd_q;
      s2_illegal_d = s1_illegal_q;
      s2_we_d      = !s1_illegal_q && (s1_rd_q != '0);
    end else if (wb_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= ALU_AND;
      s1_first_q   <= '0;
      s1_second_q  <= '0;
      s1_shamt_q   <= '0;
      s1_rd_q      <= '0;
      s1_illegal_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_zero_q    <= 1'b0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
      s2_we_q      <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_first_q   <= s1_first_d;
      s1_second_q  <= s1_second_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_rd_q      <= s1_rd_d;
      s1_illegal_q <= s1_illegal_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_zero_q    <= s2_zero_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
      s2_we_q      <= s2_we_d;
    end
  end

  assign alu_op     = s1_op_q;
  assign alu_first  = s1_first_q;
  assign alu_second = s1_second_q;
  assign alu_shamt  = s1_shamt_q;

  assign wb_valid   = s2_valid_q;
  assign wb_we      = s2_we_q;
  assign wb_rd      = s2_rd_q;
  assign wb_data    = s2_data_q;
  assign wb_zero    = s2_zero_q;
  assign wb_illegal = s2_illegal_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_retired_q, stat_retired_d;
  logic [15:0] stat_illegal_q, stat_illegal_d;
  logic        retire;

  assign retire = s2_valid_q && wb_ready;

  // Counters wrap naturally at their maximum.
  always_comb begin
    stat_retired_d = stat_retired_q;
    stat_illegal_d = stat_illegal_q;
    if (retire) begin
      stat_retired_d = stat_retired_q + 32'd1;
      if (s2_illegal_q) stat_illegal_d = stat_illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_retired_q <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_retired_q <= stat_retired_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_retired = stat_retired_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic [3:0]  alu_op;
  logic [31:0] alu_first;
  logic [31:0] alu_second;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        wb_illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_retired;
  logic [15:0] stat_illegal;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .RD_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_shamt   (in_shamt),
    .in_rd      (in_rd),
    .alu_op     (alu_op),
    .alu_first  (alu_first),
    .alu_second (alu_second),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_zero    (wb_zero),
`ifdef ALU_ISSUE_STATS_EN
    .stat_retired (stat_retired),
    .stat_illegal (stat_illegal),
`endif
    .wb_illegal (wb_illegal)
  );

  // External ALU: combinational from the issued operands.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_first & alu_second;
      4'b0001: alu_result = alu_first | alu_second;
      4'b0010: alu_result = alu_first + alu_second;
      4'b0110: alu_result = alu_first - alu_second;
      4'b0111: alu_result = {31'h0, $signed(alu_first) < $signed(alu_second)};
      4'b1100: alu_result = ~(alu_first | alu_second);
      4'b1101: alu_result = alu_first << alu_shamt;
      4'b1110: alu_result = alu_first >> alu_shamt;
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one request, checks it is accepted, then deasserts valid.
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [4:0] rd);
    in_funct = f;
    in_rs    = rs;
    in_rt    = rt;
    in_shamt = sh;
    in_rd    = rd;
    in_valid = 1'b1;
    chk("issue_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic zero,
                            input logic we, input logic [4:0] rd, input logic ill);
    $display("beat %s: valid=%0b rd=%0d data=%h zero=%0b we=%0b illegal=%0b",
             tag, wb_valid, wb_rd, wb_data, wb_zero, wb_we, wb_illegal);
    chk({tag, "_valid"},   {31'h0, wb_valid},   32'h1);
    chk({tag, "_data"},    wb_data,             data);
    chk({tag, "_zero"},    {31'h0, wb_zero},    {31'h0, zero});
    chk({tag, "_we"},      {31'h0, wb_we},      {31'h0, we});
    chk({tag, "_rd"},      {27'h0, wb_rd},      {27'h0, rd});
    chk({tag, "_illegal"}, {31'h0, wb_illegal}, {31'h0, ill});
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_funct = 6'h0;
    in_rs    = 32'h0;
    in_rt    = 32'h0;
    in_shamt = 5'h0;
    in_rd    = 5'h0;
    wb_ready = 1'b1;
    tick();
    tick();
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_we",    {31'h0, wb_we},    32'h0);
    chk("rst_wb_data",  wb_data,           32'h0);
    chk("rst_wb_ill",   {31'h0, wb_illegal}, 32'h0);
    chk("rst_alu_op",   {28'h0, alu_op},   32'h0);
    chk("rst_alu_first", alu_first,        32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    reset = 1'b0;
    tick();

    // ADD
    issue(6'h20, 32'd5, 32'd17, 5'd0, 5'd3);
    chk("add_alu_op",     {28'h0, alu_op}, 32'h2);
    chk("add_alu_first",  alu_first,       32'd5);
    chk("add_alu_second", alu_second,      32'd17);
    chk("add_wb_early",   {31'h0, wb_valid}, 32'h0);
    tick();
    check_beat("add", 32'd22, 1'b0, 1'b1, 5'd3, 1'b0);

    // SUB negative and zero result
    issue(6'h22, 32'd95, 32'd450, 5'd0, 5'd8);
    tick();
    check_beat("sub_neg", 32'hFFFFFE9D, 1'b0, 1'b1, 5'd8, 1'b0);
    issue(6'h23, 32'd888, 32'd888, 5'd9, 5'd9);
    chk("sub_alu_shamt", {27'h0, alu_shamt}, 32'h0);
    tick();
    check_beat("sub_zero", 32'd0, 1'b1, 1'b1, 5'd9, 1'b0);

    // SLL, SRL, SLT
    issue(6'h00, 32'd1234, 32'd85, 5'd3, 5'd10);
    chk("sll_alu_op",     {28'h0, alu_op},   32'hD);
    chk("sll_alu_first",  alu_first,         32'd85);
    chk("sll_alu_second", alu_second,        32'd0);
    chk("sll_alu_shamt",  {27'h0, alu_shamt}, 32'd3);
    tick();
    check_beat("sll", 32'd680, 1'b0, 1'b1, 5'd10, 1'b0);
    issue(6'h02, 32'd0, 32'h80000000, 5'd4, 5'd11);
    chk("srl_alu_op", {28'h0, alu_op}, 32'hE);
    tick();
    check_beat("srl", 32'h08000000, 1'b0, 1'b1, 5'd11, 1'b0);
    issue(6'h2A, 32'd15, 32'd16, 5'd0, 5'd12);
    tick();
    check_beat("slt", 32'd1, 1'b0, 1'b1, 5'd12, 1'b0);

    // Illegal funct and rd=0 retire without a write
    issue(6'h18, 32'd7, 32'd9, 5'd2, 5'd4);
    chk("ill_alu_op",    {28'h0, alu_op}, 32'h0);
    chk("ill_alu_first", alu_first,       32'h0);
    tick();
    check_beat("ill", 32'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    issue(6'h21, 32'd1, 32'd2, 5'd0, 5'd0);
    tick();
    check_beat("rd0", 32'd3, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);

    // Backpressure: AND, OR, NOR with wb_ready low
    wb_ready = 1'b0;
    issue(6'h24, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd1);
    issue(6'h25, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd2);
    in_funct = 6'h27;
    in_rs    = 32'h0000FFFF;
    in_rt    = 32'h00FF0000;
    in_rd    = 5'd13;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_alu_op",   {28'h0, alu_op},   32'h1);
      check_beat("bp_and", 32'h0000F000, 1'b0, 1'b1, 5'd1, 1'b0);
      if (i < 2) tick();
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_nor_op", {28'h0, alu_op}, 32'hC);
    check_beat("bp_or", 32'h0000FFF0, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();
    check_beat("bp_nor", 32'hFF000000, 1'b0, 1'b1, 5'd13, 1'b0);
    tick();
    chk("bp_drained", {31'h0, wb_valid}, 32'h0);

    // Reset with both stages full
    wb_ready = 1'b0;
    issue(6'h20, 32'd1, 32'd1, 5'd0, 5'd5);
    issue(6'h20, 32'd2, 32'd2, 5'd0, 5'd6);
    chk("full_wb_valid", {31'h0, wb_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("arst_wb_data",  wb_data,           32'h0);
    chk("arst_alu_op",   {28'h0, alu_op},   32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    wb_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {31'h0, wb_valid}, 32'h0);
    issue(6'h20, 32'd100, 32'd200, 5'd0, 5'd7);
    tick();
    check_beat("post_rst", 32'd300, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    chk("post_rst_drain", {31'h0, wb_valid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Execute-stage initiator for the 32-bit ALU. Accepts decoded MIPS R-type requests (funct, rs/rt values, shamt, rd) over a valid/ready handshake and maps funct to the 4-bit ALU op. Drives the external ALU from registered operands, captures result/zero, and presents a write-back beat to the register-file side. Two-stage pipeline with full backpressure, throughput 1 op/cycle.

Parameters:
WIDTH, 32, datapath width (ALU operand/result)
RD_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_funct  in  6  MIPS funct field
in_rs  in  WIDTH  rs register value
in_rt  in  WIDTH  rt register value
in_shamt  in  5  shift amount
in_rd  in  RD_W  destination register
alu_op  out  4  op to ALU
alu_first  out  WIDTH  ALU first operand
alu_second  out  WIDTH  ALU second operand
alu_shamt  out  5  ALU shift amount
alu_result  in  WIDTH  ALU result (combinational from alu_* outputs)
alu_zero  in  1  ALU zero flag
wb_valid  out  1  write-back beat valid
wb_ready  in  1  consumer accepts beat
wb_we  out  1  register write enable
wb_rd  out  RD_W  destination register
wb_data  out  WIDTH  result
wb_zero  out  1  captured zero flag
wb_illegal  out  1  unsupported funct

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0; wb_valid=0, wb_we=0, wb_illegal=0, wb_zero=0, wb_data=0, wb_rd=0; alu_op=0000, alu_first/second=0, alu_shamt=0.
- Funct map: 0x24 AND->0000; 0x25 OR->0001; 0x20/0x21 ADD->0010; 0x22/0x23 SUB->0110; 0x2A SLT->0111; 0x27 NOR->1100; 0x00 SLL->1101; 0x02 SRL->1110; anything else illegal.
- Operands: non-shift ops first=rs, second=rt, shamt=0; SLL/SRL first=rt, second=0, shamt=in_shamt. Illegal: op=0000, operands 0.
- Stage 1 (EX): registers decoded op/operands/rd/illegal; alu_* driven directly from S1 registers.
- Stage 2 (WB): captures alu_result, alu_zero, rd, illegal when S1 advances.
- s1_adv = s1_valid && (!s2_valid || wb_ready); in_ready = !s1_valid || s1_adv (combinational, no extra bubble).
- Latency: accept at edge N -> ALU operands valid cycle N..N+1 -> wb_valid from edge N+1; back-to-back accepts give one beat per cycle while wb_ready=1.
- wb_valid held with all wb_* stable until wb_ready; S1 holds and ALU outputs stay constant while stalled.
- wb_we = !illegal && rd!=0. rd=0 and illegal beats still produce wb_valid (retire), with wb_we=0; illegal beat forces wb_data=0, wb_zero=0, wb_illegal=1.
- Simultaneous accept into S1 and drain from S2 in the same cycle is legal, no loss.
- Reset mid-operation discards both stages; no partial beat after reset release.

Optional Feature:
ALU_ISSUE_STATS_EN: when defined, adds outputs stat_retired (32) and stat_illegal (16), counters incremented on each wb_valid&&wb_ready beat (illegal counter only when wb_illegal), wrap at max, cleared by reset. Undefined: ports and counters absent, core behaviour identical.

Decomposition:
- Package alu_pkg: ALU op localparams (ALU_AND..ALU_SRL), funct localparams, op width 4.
- One sub-module alu_funct_decode (combinational funct -> op, is_shift, illegal), reused by future control logic.

Test Plan:
- ADD funct 0x20, rs=5, rt=17, rd=3, wb_ready=1 -> alu_op=0010, one cycle later wb_valid, wb_data=22, wb_we=1, wb_rd=3, wb_zero=0.
- SUB 0x22 rs=95, rt=450 -> wb_data=0xFFFFFE9D; SUB rs=888, rt=888 -> wb_data=0, wb_zero=1.
- SLL 0x00 rt=85, shamt=3 -> alu_first=85, alu_op=1101, wb_data=680; SLT 0x2A rs=15, rt=16 -> wb_data=1.
- Back-to-back AND/OR/NOR with wb_ready low 3 cycles -> in_ready drops once S1,S2 full, wb_* stable, all three results retire in order, none dropped.
- funct 0x18 -> wb_illegal=1, wb_we=0, wb_data=0; rd=0 ADD -> wb_valid=1, wb_we=0.
- Assert reset while both stages full -> wb_valid=0 immediately (async), after release first beat is the next accepted request.
